fwrisc_wb_arbiter: RTL and testbench

Two-initiator to one-target Wishbone arbiter letting the fwrisc core's instruction port (wbi_) and data port (wbd_) share one single-ported memory/bus target (wbt_). Round-robin grant, one transfer per grant, registered grant state, combinational request/response muxing once granted.

---
 rtl/fwrisc_wb_arb_pkg.sv | 16 +
 rtl/fwrisc_wb_arbiter.sv | 164 ++++++++++++++++
 tb/tb_fwrisc_wb_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/fwrisc_wb_arb_pkg.sv
// Shared types for the fwrisc two-initiator Wishbone arbiter.
// Grant states, initiator ids and watchdog counter width.
package fwrisc_wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } arb_state_e;

  localparam logic INIT_I = 1'b0;
  localparam logic INIT_D = 1'b1;

  localparam int TO_CNT_W = 16;

endpackage

// File: rtl/fwrisc_wb_arbiter.sv
// Round-robin arbiter: fwrisc wbi_/wbd_ ports onto one wbt_ target.
// Optional watchdog enabled by defining FWRISC_WB_ARB_TIMEOUT_EN.
module fwrisc_wb_arbiter
  import fwrisc_wb_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   wbi_adr,
  input  logic [DATA_WIDTH-1:0]   wbi_dat_w,
  output logic [DATA_WIDTH-1:0]   wbi_dat_r,
  input  logic                    wbi_cyc,
  output logic                    wbi_err,
  input  logic [DATA_WIDTH/8-1:0] wbi_sel,
  input  logic                    wbi_stb,
  output logic                    wbi_ack,
  input  logic                    wbi_we,
  input  logic [ADDR_WIDTH-1:0]   wbd_adr,
  input  logic [DATA_WIDTH-1:0]   wbd_dat_w,
  output logic [DATA_WIDTH-1:0]   wbd_dat_r,
  input  logic                    wbd_cyc,
  output logic                    wbd_err,
  input  logic [DATA_WIDTH/8-1:0] wbd_sel,
  input  logic                    wbd_stb,
  output logic                    wbd_ack,
  input  logic                    wbd_we,
  output logic [ADDR_WIDTH-1:0]   wbt_adr,
  output logic [DATA_WIDTH-1:0]   wbt_dat_w,
  input  logic [DATA_WIDTH-1:0]   wbt_dat_r,
  output logic                    wbt_cyc,
  input  logic                    wbt_err,
  output logic [DATA_WIDTH/8-1:0] wbt_sel,
  output logic                    wbt_stb,
  input  logic                    wbt_ack,
  output logic                    wbt_we
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_to
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

  arb_state_e state_q, state_d;
  logic       last_q, last_d;

  logic req_i, req_d;
  logic sel_d;
  logic m_cyc, m_stb, m_we;
  logic [ADDR_WIDTH-1:0]   m_adr;
  logic [DATA_WIDTH-1:0]   m_dat;
  logic [DATA_WIDTH/8-1:0] m_sel;
  logic done, to_hit, ack_x, err_x;

`ifdef FWRISC_WB_ARB_TIMEOUT_EN
  localparam logic [TO_CNT_W-1:0] TO_LAST =
    TO_CNT_W'(TIMEOUT_CYCLES - 1);
  logic [TO_CNT_W-1:0] cnt_q, cnt_d;
`endif

  assign req_i = wbi_cyc & wbi_stb;
  assign req_d = wbd_cyc & wbd_stb;

  // Read data is broadcast; only the acked initiator samples it.
  assign wbi_dat_r = wbt_dat_r;
  assign wbd_dat_r = wbt_dat_r;

  // Select the granted initiator's request signals.
  always_comb begin
    sel_d = (state_q == ST_GNT_D);
    m_cyc = sel_d ? wbd_cyc   : wbi_cyc;
    m_stb = sel_d ? wbd_stb   : wbi_stb;
    m_we  = sel_d ? wbd_we    : wbi_we;
    m_adr = sel_d ? wbd_adr   : wbi_adr;
    m_dat = sel_d ? wbd_dat_w : wbi_dat_w;
    m_sel = sel_d ? wbd_sel   : wbi_sel;
  end

  // Next-state, grant muxing and response routing.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    wbt_cyc   = 1'b0;
    wbt_stb   = 1'b0;
    wbt_we    = 1'b0;
    wbt_adr   = '0;
    wbt_dat_w = '0;
    wbt_sel   = '0;
    wbi_ack   = 1'b0;
    wbi_err   = 1'b0;
    wbd_ack   = 1'b0;
    wbd_err   = 1'b0;
    done      = 1'b0;
    to_hit    = 1'b0;
    ack_x     = 1'b0;
    err_x     = 1'b0;
`ifdef FWRISC_WB_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
`ifdef FWRISC_WB_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (req_i && (!req_d || last_q == INIT_D))
          state_d = ST_GNT_I;
        else if (req_d)
          state_d = ST_GNT_D;
      end
      ST_GNT_I, ST_GNT_D: begin
        wbt_cyc   = m_cyc;
        wbt_stb   = m_stb;
        wbt_we    = m_we;
        wbt_adr   = m_adr;
        wbt_dat_w = m_dat;
        wbt_sel   = m_sel;
        done = !m_cyc || wbt_ack || wbt_err;
`ifdef FWRISC_WB_ARB_TIMEOUT_EN
        to_hit = !done && (cnt_q == TO_LAST);
        if (!done && !to_hit)
          cnt_d = cnt_q + 1'b1;
`endif
        if (to_hit) begin
          wbt_cyc = 1'b0;
          wbt_stb = 1'b0;
        end
        ack_x = wbt_ack;
        err_x = wbt_err | to_hit;
        wbi_ack = !sel_d & ack_x;
        wbi_err = !sel_d & err_x;
        wbd_ack = sel_d & ack_x;
        wbd_err = sel_d & err_x;
        if (done || to_hit) begin
          state_d = ST_IDLE;
          last_d  = sel_d ? INIT_D : INIT_I;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant state; last grant starts at D so the first fetch wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      last_q  <= INIT_D;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

`ifdef FWRISC_WB_ARB_TIMEOUT_EN
  // Watchdog counter for the current grant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_fwrisc_wb_arbiter.sv
// Directed bench for fwrisc_wb_arbiter.
// Vector table plus sequences for abort, reset and watchdog.
module tb_fwrisc_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] wbi_adr, wbi_dat_w, wbi_dat_r;
  logic        wbi_cyc, wbi_err, wbi_stb, wbi_ack, wbi_we;
  logic [3:0]  wbi_sel;
  logic [31:0] wbd_adr, wbd_dat_w, wbd_dat_r;
  logic        wbd_cyc, wbd_err, wbd_stb, wbd_ack, wbd_we;
  logic [3:0]  wbd_sel;
  logic [31:0] wbt_adr, wbt_dat_w, wbt_dat_r;
  logic        wbt_cyc, wbt_err, wbt_stb, wbt_ack, wbt_we;
  logic [3:0]  wbt_sel;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clock = ~clock;

  fwrisc_wb_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock), .reset(reset),
    .wbi_adr(wbi_adr), .wbi_dat_w(wbi_dat_w),
    .wbi_dat_r(wbi_dat_r), .wbi_cyc(wbi_cyc),
    .wbi_err(wbi_err), .wbi_sel(wbi_sel),
    .wbi_stb(wbi_stb), .wbi_ack(wbi_ack), .wbi_we(wbi_we),
    .wbd_adr(wbd_adr), .wbd_dat_w(wbd_dat_w),
    .wbd_dat_r(wbd_dat_r), .wbd_cyc(wbd_cyc),
    .wbd_err(wbd_err), .wbd_sel(wbd_sel),
    .wbd_stb(wbd_stb), .wbd_ack(wbd_ack), .wbd_we(wbd_we),
    .wbt_adr(wbt_adr), .wbt_dat_w(wbt_dat_w),
    .wbt_dat_r(wbt_dat_r), .wbt_cyc(wbt_cyc),
    .wbt_err(wbt_err), .wbt_sel(wbt_sel),
    .wbt_stb(wbt_stb), .wbt_ack(wbt_ack), .wbt_we(wbt_we)
  );

  typedef struct {
    logic        rst;
    logic        icyc, istb, dcyc, dstb, dwe;
    logic [3:0]  dsel;
    logic        tack, terr;
    logic [31:0] tdat;
    logic        e_cyc;
    logic [31:0] e_adr;
    logic        e_we;
    logic [3:0]  e_sel;
    logic        e_iack, e_ierr, e_dack, e_derr;
  } vec_t;

  vec_t vt [$];

  localparam logic [31:0] AI = 32'h200;
  localparam logic [31:0] AD = 32'h100;

  function automatic vec_t mkv(
    logic rst, logic icyc, logic istb, logic dcyc,
    logic dstb, logic dwe, logic [3:0] dsel,
    logic tack, logic terr, logic [31:0] tdat,
    logic ec, logic [31:0] ea, logic ew, logic [3:0] es,
    logic ia, logic ie, logic da, logic de);
    vec_t v;
    v.rst = rst; v.icyc = icyc; v.istb = istb;
    v.dcyc = dcyc; v.dstb = dstb; v.dwe = dwe;
    v.dsel = dsel; v.tack = tack; v.terr = terr;
    v.tdat = tdat; v.e_cyc = ec; v.e_adr = ea;
    v.e_we = ew; v.e_sel = es; v.e_iack = ia;
    v.e_ierr = ie; v.e_dack = da; v.e_derr = de;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic drive_idle();
    wbi_cyc = 0; wbi_stb = 0;
    wbd_cyc = 0; wbd_stb = 0; wbd_we = 0; wbd_sel = 4'hF;
    wbt_ack = 0; wbt_err = 0; wbt_dat_r = 32'h0;
  endtask

  initial begin
    wbi_adr = AI; wbi_dat_w = 32'h1111_1111;
    wbi_sel = 4'hF; wbi_we = 1'b0;
    wbd_adr = AD; wbd_dat_w = 32'h2222_2222;
    drive_idle();

    // D-only read, ack two cycles after strobe; stray ack in idle
    vt.push_back(mkv(1,0,0,1,1,0,4'hF,0,0,0,          0,0,0,0,   0,0,0,0));
    vt.push_back(mkv(0,0,0,1,1,0,4'hF,0,0,0,          1,AD,0,4'hF,0,0,0,0));
    vt.push_back(mkv(0,0,0,1,1,0,4'hF,0,0,0,          1,AD,0,4'hF,0,0,0,0));
    vt.push_back(mkv(0,0,0,1,1,0,4'hF,1,0,32'hCAFEF00D,1,AD,0,4'hF,0,0,1,0));
    vt.push_back(mkv(0,0,0,0,0,0,4'hF,1,0,0,          0,0,0,0,   0,0,0,0));
    // Both requesting: I, D, I, D with idle bubbles
    vt.push_back(mkv(1,1,1,1,1,0,4'hF,0,0,0,          0,0,0,0,   0,0,0,0));
    vt.push_back(mkv(0,1,1,1,1,0,4'hF,1,0,32'h11,     1,AI,0,4'hF,1,0,0,0));
    vt.push_back(mkv(0,1,1,1,1,0,4'hF,0,0,0,          0,0,0,0,   0,0,0,0));
    vt.push_back(mkv(0,1,1,1,1,0,4'hF,1,0,32'h22,     1,AD,0,4'hF,0,0,1,0));
    vt.push_back(mkv(0,1,1,1,1,0,4'hF,0,0,0,          0,0,0,0,   0,0,0,0));
    vt.push_back(mkv(0,1,1,1,1,0,4'hF,1,0,32'h33,     1,AI,0,4'hF,1,0,0,0));
    vt.push_back(mkv(0,1,1,1,1,0,4'hF,0,0,0,          0,0,0,0,   0,0,0,0));
    vt.push_back(mkv(0,1,1,1,1,0,4'hF,1,0,32'h44,     1,AD,0,4'hF,0,0,1,0));
    vt.push_back(mkv(0,0,0,0,0,0,4'hF,0,0,0,          0,0,0,0,   0,0,0,0));
    // D write sel=3 gets target error; pending I wins next
    vt.push_back(mkv(1,0,0,1,1,1,4'h3,0,0,0,          0,0,0,0,   0,0,0,0));
    vt.push_back(mkv(0,1,1,1,1,1,4'h3,0,1,0,          1,AD,1,4'h3,0,0,0,1));
    vt.push_back(mkv(0,1,1,1,1,1,4'h3,0,0,0,          0,0,0,0,   0,0,0,0));
    vt.push_back(mkv(0,1,1,1,1,1,4'h3,1,0,32'h55,     1,AI,0,4'hF,1,0,0,0));
    vt.push_back(mkv(0,0,0,0,0,0,4'hF,0,0,0,          0,0,0,0,   0,0,0,0));

    pulse_reset();
    for (int i = 0; i < vt.size(); i++) begin
      vec_t v;
      v = vt[i];
      @(negedge clock);
      if (v.rst) begin
        reset = 1'b0;
        #1;
        chk($sformatf("rst_cyc[%0d]", i),
            {62'd0, wbt_cyc, wbt_stb}, 64'd0);
        reset = 1'b1;
      end
      wbi_cyc = v.icyc; wbi_stb = v.istb;
      wbd_cyc = v.dcyc; wbd_stb = v.dstb;
      wbd_we = v.dwe; wbd_sel = v.dsel;
      wbt_ack = v.tack; wbt_err = v.terr;
      wbt_dat_r = v.tdat;
      #1;
      chk($sformatf("vec[%0d]", i),
          {22'd0, wbt_cyc, wbt_stb, wbt_adr, wbt_we, wbt_sel,
           wbi_ack, wbi_err, wbd_ack, wbd_err},
          {22'd0, v.e_cyc, v.e_cyc, v.e_adr, v.e_we, v.e_sel,
           v.e_iack, v.e_ierr, v.e_dack, v.e_derr});
      if (v.e_dack)
        chk($sformatf("vec[%0d] dat_r", i),
            {32'd0, wbd_dat_r}, {32'd0, v.tdat});
      if (v.e_iack)
        chk($sformatf("vec[%0d] dat_r", i),
            {32'd0, wbi_dat_r}, {32'd0, v.tdat});
    end

    // Abort: I drops cyc mid-grant, pending D served next
    @(negedge clock); drive_idle();
    pulse_reset();
    wbi_cyc = 1; wbi_stb = 1; wbd_cyc = 1; wbd_stb = 1;
    #1 chk("abort idle", {63'd0, wbt_cyc}, 64'd0);
    @(negedge clock); #1;
    chk("abort gnt1", {31'd0, wbt_cyc, wbt_adr}, {31'd1, AI});
    @(negedge clock); #1;
    chk("abort gnt2", {63'd0, wbt_cyc}, 64'd1);
    @(negedge clock);
    wbi_cyc = 0; wbi_stb = 0;
    #1 chk("abort drop", {62'd0, wbt_cyc, wbi_ack}, 64'd0);
    @(negedge clock); #1;
    chk("abort bubble", {63'd0, wbt_cyc}, 64'd0);
    @(negedge clock); #1;
    chk("abort d gnt", {31'd0, wbt_cyc, wbt_adr}, {31'd1, AD});
    wbt_ack = 1; #1;
    chk("abort d ack", {62'd0, wbd_ack, wbi_ack}, 64'd2);
    @(negedge clock); drive_idle();

    // Asynchronous reset in the middle of a grant
    pulse_reset();
    wbi_cyc = 1; wbi_stb = 1;
    @(negedge clock); #1;
    chk("rstmid gnt", {63'd0, wbt_cyc}, 64'd1);
    #1 reset = 1'b0;
    #1 chk("rstmid drop", {61'd0, wbt_cyc, wbt_stb, wbi_ack},
           64'd0);
    @(negedge clock);
    reset = 1'b1;
    #1 chk("rstmid idle", {63'd0, wbt_cyc}, 64'd0);
    @(negedge clock); #1;
    chk("rstmid regnt", {63'd0, wbt_cyc}, 64'd1);

    // Unacked target: watchdog fires on grant cycle 8, else holds
    @(negedge clock); drive_idle();
    pulse_reset();
    wbi_cyc = 1; wbi_stb = 1;
`ifdef FWRISC_WB_ARB_TIMEOUT_EN
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock); #1;
      chk($sformatf("wdog[%0d]", k),
          {62'd0, wbt_cyc, wbi_err},
          {62'd0, (k < 8), (k == 8)});
    end
`else
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock); #1;
      chk($sformatf("hold[%0d]", k),
          {62'd0, wbt_cyc, wbi_err}, 64'd2);
    end
    wbt_ack = 1; #1;
    chk("hold ack", {63'd0, wbi_ack}, 64'd1);
`endif
    @(negedge clock); drive_idle();
    @(negedge clock);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
